kbd_scanbuf: RTL and testbench
==============================

Name: kbd_scanbuf

Overview:
- Sits between the PS/2 receiver (`ps2keyboard`, CLOCK_50 domain) and the memory controller's keyboard port.
- Turns raw Set-2 scancode bytes into decoded key events:
  - folds the E0 (extended) and F0 (break) prefixes into flag bits;
  - swallows the Pause (E1) sequence;
  - drops controller status bytes.
- Buffers events in a first-word-fall-through FIFO, so the CPU can read keys at its own pace without losing bursts.

Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 entries (16).
- TIMEOUT, 2500000, cycles a prefix state may wait for its next byte before falling back to IDLE (50 ms at 50 MHz).

Ports:
- clock  in  1  system clock (CLOCK_50); every register is updated on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_data  in  8  received byte; valid only when ps2_hit=1.
- ps2_hit  in  1  one-cycle strobe: a new byte is present on ps2_data.
- kb_pop  in  1  one-cycle strobe: discard the head entry.
- ovf_clr  in  1  clears the sticky overflow flag.
- kb_ready  out  1  FIFO not empty.
- kb_code  out  8  head entry scancode; 0 when empty.
- kb_flags  out  2  head entry flags: [1]=ext (E0/E1 prefixed), [0]=release (F0 seen); 0 when empty.
- kb_count  out  DEPTH_LOG2+1  number of stored entries.
- kb_ovf  out  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, decoder state IDLE, FIFO pointers and count 0, timeout counter 0.
- Decoder FSM advances only on cycles with ps2_hit=1, except for the timeout. States:
  - IDLE:
    - E0 -> EXT
    - F0 -> REL
    - E1 -> PAUSE with skip counter = 7
    - AA, FA, FE, EE, 00, FF -> discarded, stay IDLE
    - any other byte b -> push {ext=0, rel=0, b}, stay IDLE
  - EXT:
    - F0 -> EXTREL
    - E0 -> stay EXT
    - any other byte b (including AA/FA etc.) -> push {1, 0, b}, go IDLE
  - REL: any byte b -> push {0, 1, b}, go IDLE.
  - EXTREL: any byte b -> push {1, 1, b}, go IDLE.
  - PAUSE:
    - Each byte decrements the skip counter.
    - When the counter reaches 0 on a byte, push {1, 0, E1} and go IDLE.
    - Net effect: exactly one event per 8-byte Pause sequence.
- Timeout:
  - In any state other than IDLE, the counter increments on every cycle without ps2_hit and reloads to 0 on ps2_hit.
  - On reaching TIMEOUT-1 the FSM returns to IDLE and nothing is pushed.
  - In IDLE the counter is held at 0.
- Push latency: a byte that completes an event at edge N makes kb_ready/kb_code/kb_flags valid after edge N+1.
  - This applies when the FIFO was previously empty.
  - FWFT: the head is always presented on the outputs with no read latency.
- Pop:
  - kb_pop with kb_ready=1 advances the head; the next entry (or zeros) is visible after the same edge.
  - kb_pop while empty is ignored; count stays 0 and there is no underflow.
- Simultaneous push and pop in the same cycle:
  - both take effect and count is unchanged;
  - this holds even when full — the pop frees the slot, so no overflow;
  - when empty, the push takes effect and the pop is ignored.
- Full (count = 2^DEPTH_LOG2) with a push and no pop: the new event is dropped, FIFO contents are untouched, and kb_ovf is set.
- kb_ovf: set and ovf_clr asserted in the same cycle -> set wins.
- Pointers wrap modulo 2^DEPTH_LOG2. kb_count is one bit wider than the pointers so it can represent full.
- Reset asserted mid-sequence (e.g. after E0) discards the partial prefix and all buffered entries.

Test Plan:
- Reset, then hit 1C ("A" make) -> one cycle later kb_ready=1, kb_code=1C, kb_flags=00, kb_count=1. Pop -> kb_ready=0, kb_code=00.
- Sequence E0 F0 75 (Up release) -> exactly one entry {flags=11, code=75}. Sequence F0 1C -> {01, 1C}. Sequence E0 75 -> {10, 75}.
- Bytes AA, FA, 00 in IDLE -> no entries. Full Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one entry {10, E1}.
- Hit E0, wait TIMEOUT cycles (use a small TIMEOUT, e.g. 8), then hit 1C -> entry {00, 1C}, not {10, 1C}.
- Push 17 distinct codes with no pop, DEPTH_LOG2=4:
  - kb_count=16 and kb_ovf=1;
  - popping all 16 returns the first 16 codes in order; the 17th is absent.
  - Pulse ovf_clr -> kb_ovf=0.
- With the FIFO full, assert ps2_hit (completing 2D) and kb_pop in the same cycle -> kb_count stays 16, kb_ovf stays 0, and 2D appears last after draining.
- Assert reset one cycle after E0 -> then hit 1C -> {00, 1C}.

Source files
------------

// File: rtl/kbd_scanbuf_if.sv
// kbd_scanbuf_if: bundles the PS/2 byte input and the CPU-side key FIFO port of kbd_scanbuf.
//   ps2_data/ps2_hit : received Set-2 byte and its one-cycle strobe
//   kb_pop/ovf_clr   : discard head entry / clear sticky overflow
//   kb_ready/kb_code/kb_flags/kb_count/kb_ovf : FWFT head entry, fill level, overflow flag
// master drives the inputs (PS/2 receiver + CPU side), slave is the buffer itself.
interface kbd_scanbuf_if #(
  parameter int unsigned DEPTH_LOG2 = 4
) ();
  logic [7:0]          ps2_data;
  logic                ps2_hit;
  logic                kb_pop;
  logic                ovf_clr;
  logic                kb_ready;
  logic [7:0]          kb_code;
  logic [1:0]          kb_flags;
  logic [DEPTH_LOG2:0] kb_count;
  logic                kb_ovf;

  modport master (
    output ps2_data, ps2_hit, kb_pop, ovf_clr,
    input  kb_ready, kb_code, kb_flags, kb_count, kb_ovf
  );

  modport slave (
    input  ps2_data, ps2_hit, kb_pop, ovf_clr,
    output kb_ready, kb_code, kb_flags, kb_count, kb_ovf
  );
endinterface

// File: rtl/kbd_scanbuf.sv
// kbd_scanbuf: decodes raw PS/2 Set-2 scancode bytes into key events and buffers them in a
// first-word-fall-through FIFO.
//   clock : system clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : kbd_scanbuf_if.slave (byte input, FIFO head/pop, count, sticky overflow)
// Event format {ext, rel, code}: ext = E0/E1 prefixed, rel = F0 (break) seen.
module kbd_scanbuf #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT    = 2500000
) (
  input logic          clock,
  input logic          reset,
  kbd_scanbuf_if.slave bus
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned TmrW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [TmrW-1:0]     TmrLast   = TmrW'(TIMEOUT - 2);

  typedef enum logic [2:0] {StIdle, StExt, StRel, StExtRel, StPause} state_e;

  // Controller status/ack bytes that never carry a key event when seen outside a prefix.
  function automatic logic is_status(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  state_e          state_q;
  logic [2:0]      skip_q;
  logic [TmrW-1:0] tmr_q;
  logic            push_q;
  logic [9:0]      push_data_q;

  // Decoder. The completed event is registered and written into the FIFO on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      skip_q      <= 3'd0;
      tmr_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= 10'd0;
    end else begin
      push_q <= 1'b0;
      if (bus.ps2_hit) begin
        tmr_q <= '0;
        case (state_q)
          StIdle: begin
            if (bus.ps2_data == 8'hE0) begin
              state_q <= StExt;
            end else if (bus.ps2_data == 8'hF0) begin
              state_q <= StRel;
            end else if (bus.ps2_data == 8'hE1) begin
              state_q <= StPause;
              skip_q  <= 3'd7;
            end else if (!is_status(bus.ps2_data)) begin
              push_q      <= 1'b1;
              push_data_q <= {2'b00, bus.ps2_data};
            end
          end
          StExt: begin
            if (bus.ps2_data == 8'hF0) begin
              state_q <= StExtRel;
            end else if (bus.ps2_data != 8'hE0) begin
              push_q      <= 1'b1;
              push_data_q <= {2'b10, bus.ps2_data};
              state_q     <= StIdle;
            end
          end
          StRel: begin
            push_q      <= 1'b1;
            push_data_q <= {2'b01, bus.ps2_data};
            state_q     <= StIdle;
          end
          StExtRel: begin
            push_q      <= 1'b1;
            push_data_q <= {2'b11, bus.ps2_data};
            state_q     <= StIdle;
          end
          StPause: begin
            // Remaining bytes of the Pause sequence collapse into a single E1 event.
            if (skip_q == 3'd1) begin
              push_q      <= 1'b1;
              push_data_q <= {2'b10, 8'hE1};
              state_q     <= StIdle;
            end
            skip_q <= skip_q - 3'd1;
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle) begin
        // Abandon a stale prefix once the counter reaches TIMEOUT-1.
        if (tmr_q == TmrLast) begin
          state_q <= StIdle;
          tmr_q   <= '0;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
      end
    end
  end

  logic [9:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ovf_q;
  logic                  empty;
  logic                  full;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  ovf_set;
  logic [9:0]            head;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FullCount);
    pop_ok  = bus.kb_pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok = push_q && (!full || pop_ok);
    ovf_set = push_q && full && !pop_ok;
    head    = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.kb_ready = !empty;
  assign bus.kb_code  = empty ? 8'h00 : head[7:0];
  assign bus.kb_flags = empty ? 2'b00 : head[9:8];
  assign bus.kb_count = count_q;
  assign bus.kb_ovf   = ovf_q;

endmodule

// File: tb/tb_kbd_scanbuf.sv
// tb_kbd_scanbuf: directed scenarios plus randomized traffic for kbd_scanbuf, checked against
// a byte-queue decoder model and a queue-based FIFO model.
module tb_kbd_scanbuf;
  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TO    = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  kbd_scanbuf_if #(.DEPTH_LOG2(DL)) bus ();

  kbd_scanbuf #(.DEPTH_LOG2(DL), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: bytes seen since the last idle point, pending event, FIFO contents.
  logic [7:0] m_pend[$];
  logic [9:0] m_fifo[$];
  int         m_idle;
  logic       m_stv;
  logic [9:0] m_st;
  logic       m_ovf;

  function automatic logic pend_has(input logic [7:0] b);
    foreach (m_pend[i]) if (m_pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] m_head();
    return (m_fifo.size() > 0) ? m_fifo[0] : 10'h000;
  endfunction

  task automatic m_clear();
    m_pend.delete();
    m_fifo.delete();
    m_idle = 0;
    m_stv  = 1'b0;
    m_st   = 10'h0;
    m_ovf  = 1'b0;
  endtask

  task automatic m_decode(input logic [7:0] b);
    logic e0, f0;
    m_idle = 0;
    if (m_pend.size() == 0 && b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) return;
    if (m_pend.size() > 0 && m_pend[0] == 8'hE1) begin
      m_pend.push_back(b);
      if (m_pend.size() == 8) begin
        m_stv = 1'b1;
        m_st  = {2'b10, 8'hE1};
        m_pend.delete();
      end
      return;
    end
    e0 = pend_has(8'hE0);
    f0 = pend_has(8'hF0);
    if (b == 8'hE0 && !f0) begin
      if (!e0) m_pend.push_back(b);
      return;
    end
    if (b == 8'hF0 && !f0) begin
      m_pend.push_back(b);
      return;
    end
    if (b == 8'hE1 && m_pend.size() == 0) begin
      m_pend.push_back(b);
      return;
    end
    m_stv = 1'b1;
    m_st  = {e0, f0, b};
    m_pend.delete();
  endtask

  // One clock cycle with the given inputs; the model advances at the same edge.
  task automatic step(input logic hit, input logic [7:0] d, input logic pop, input logic clr);
    logic pop_ok, accept, set;
    bus.ps2_hit  = hit;
    bus.ps2_data = d;
    bus.kb_pop   = pop;
    bus.ovf_clr  = clr;
    @(posedge clock);
    pop_ok = pop && (m_fifo.size() > 0);
    accept = m_stv && ((m_fifo.size() < DEPTH) || pop_ok);
    set    = m_stv && !accept;
    if (pop_ok) void'(m_fifo.pop_front());
    if (accept) m_fifo.push_back(m_st);
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_stv = 1'b0;
    if (hit) begin
      m_decode(d);
    end else if (m_pend.size() > 0) begin
      m_idle++;
      if (m_idle == int'(TO) - 1) begin
        m_pend.delete();
        m_idle = 0;
      end
    end
    #1;
    bus.ps2_hit = 1'b0;
    bus.kb_pop  = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    bus.ps2_hit  = 1'b0;
    bus.ps2_data = 8'h00;
    bus.kb_pop   = 1'b0;
    bus.ovf_clr  = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.kb_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready got %0b want 0", bus.kb_ready); end
    checks++; if (bus.kb_code !== 8'h00) begin errors++;
      $display("FAIL reset_code got %h want 00", bus.kb_code); end
    checks++; if (bus.kb_flags !== 2'b00) begin errors++;
      $display("FAIL reset_flags got %b want 00", bus.kb_flags); end
    checks++; if (bus.kb_count !== 5'd0) begin errors++;
      $display("FAIL reset_count got %0d want 0", bus.kb_count); end
    checks++; if (bus.kb_ovf !== 1'b0) begin errors++;
      $display("FAIL reset_ovf got %0b want 0", bus.kb_ovf); end
  endtask

  task automatic test_make_pop();
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    checks++; if (bus.kb_ready !== 1'b0) begin errors++;
      $display("FAIL make_latency ready got %0b want 0", bus.kb_ready); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bus.kb_ready !== 1'b1 || bus.kb_code !== 8'h1C || bus.kb_flags !== 2'b00 ||
                  bus.kb_count !== 5'd1) begin errors++;
      $display("FAIL make_head got rdy=%0b code=%h flg=%b cnt=%0d want 1 1C 00 1",
               bus.kb_ready, bus.kb_code, bus.kb_flags, bus.kb_count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.kb_ready !== 1'b0 || bus.kb_code !== 8'h00 || bus.kb_count !== 5'd0)
      begin errors++;
      $display("FAIL make_pop got rdy=%0b code=%h cnt=%0d want 0 00 0",
               bus.kb_ready, bus.kb_code, bus.kb_count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.kb_count !== 5'd0) begin errors++;
      $display("FAIL pop_empty count got %0d want 0", bus.kb_count); end
    // Push lands on an empty FIFO in the same cycle as a pop: pop ignored.
    step(1'b1, 8'h2D, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.kb_count !== 5'd1 || bus.kb_code !== 8'h2D) begin errors++;
      $display("FAIL push_pop_empty got cnt=%0d code=%h want 1 2D", bus.kb_count, bus.kb_code);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_prefixes();
    logic [7:0] seq[7];
    logic [9:0] exp[3];
    seq = '{8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1C, 8'hE0, 8'h75};
    exp = '{{2'b11, 8'h75}, {2'b01, 8'h1C}, {2'b10, 8'h75}};
    foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bus.kb_count !== 5'd3) begin errors++;
      $display("FAIL prefix_count got %0d want 3", bus.kb_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.kb_flags, bus.kb_code} !== exp[i]) begin errors++;
        $display("FAIL prefix_entry%0d got %h want %h", i, {bus.kb_flags, bus.kb_code}, exp[i]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (bus.kb_ready !== 1'b0) begin errors++;
      $display("FAIL prefix_drained ready got %0b want 0", bus.kb_ready); end
  endtask

  task automatic test_discard_pause();
    logic [7:0] junk[3];
    logic [7:0] pause[8];
    junk  = '{8'hAA, 8'hFA, 8'h00};
    pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (junk[i]) step(1'b1, junk[i], 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bus.kb_count !== 5'd0) begin errors++;
      $display("FAIL status_drop count got %0d want 0", bus.kb_count); end
    foreach (pause[i]) step(1'b1, pause[i], 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bus.kb_count !== 5'd1 || {bus.kb_flags, bus.kb_code} !== {2'b10, 8'hE1})
      begin errors++;
      $display("FAIL pause got cnt=%0d entry=%h want 1 2e1", bus.kb_count,
               {bus.kb_flags, bus.kb_code}); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (TO + 2) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if ({bus.kb_flags, bus.kb_code} !== {2'b00, 8'h1C}) begin errors++;
      $display("FAIL timeout_expired got %h want 01c", {bus.kb_flags, bus.kb_code}); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (TO / 2) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h75, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if ({bus.kb_flags, bus.kb_code} !== {2'b10, 8'h75}) begin errors++;
      $display("FAIL timeout_held got %h want 275", {bus.kb_flags, bus.kb_code}); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bus.kb_count !== 5'd16 || bus.kb_ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_full got cnt=%0d ovf=%0b want 16 1", bus.kb_count, bus.kb_ovf); end
    for (int i = 0; i < 16; i++) begin
      checks++; if ({bus.kb_flags, bus.kb_code} !== {2'b00, 8'(8'h10 + i)}) begin errors++;
        $display("FAIL ovf_drain%0d got %h want %h", i, {bus.kb_flags, bus.kb_code},
                 {2'b00, 8'(8'h10 + i)}); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (bus.kb_ready !== 1'b0) begin errors++;
      $display("FAIL ovf_17th_absent ready got %0b want 0", bus.kb_ready); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.kb_ovf !== 1'b0) begin errors++;
      $display("FAIL ovf_clr got %0b want 0", bus.kb_ovf); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bus.kb_count !== 5'd16) begin errors++;
      $display("FAIL b2b_fill got %0d want 16", bus.kb_count); end
    step(1'b1, 8'h2D, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bus.kb_count !== 5'd16 || bus.kb_ovf !== 1'b0) begin errors++;
      $display("FAIL b2b_hit_pop got cnt=%0d ovf=%0b want 16 0", bus.kb_count, bus.kb_ovf); end
    // Event write and pop on the same edge while full.
    step(1'b1, 8'h3E, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.kb_count !== 5'd16 || bus.kb_ovf !== 1'b0) begin errors++;
      $display("FAIL b2b_full_push_pop got cnt=%0d ovf=%0b want 16 0", bus.kb_count,
               bus.kb_ovf); end
    for (int i = 0; i < 16; i++) begin
      want = (i < 14) ? 8'(8'h32 + i) : ((i == 14) ? 8'h2D : 8'h3E);
      checks++; if (bus.kb_code !== want) begin errors++;
        $display("FAIL b2b_drain%0d got %h want %h", i, bus.kb_code, want); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    do_reset();
    checks++; if (bus.kb_count !== 5'd0) begin errors++;
      $display("FAIL reset_mid_flush got %0d want 0", bus.kb_count); end
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if ({bus.kb_flags, bus.kb_code} !== {2'b00, 8'h1C} || bus.kb_count !== 5'd1)
      begin errors++;
      $display("FAIL reset_mid got %h cnt=%0d want 01c 1", {bus.kb_flags, bus.kb_code},
               bus.kb_count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] pool[12];
    logic [9:0] h;
    pool = '{8'h1C, 8'h75, 8'h2D, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'h14, 8'h77,
             8'h5A};
    do_reset();
    for (int n = 0; n < 500; n++) begin
      step(($urandom % 100) < 65, pool[$urandom % 12], ($urandom % 100) < 25,
           ($urandom % 100) < 5);
      h = m_head();
      checks++;
      if (bus.kb_ready !== (m_fifo.size() > 0) || {bus.kb_flags, bus.kb_code} !== h ||
          bus.kb_count !== 5'(m_fifo.size()) || bus.kb_ovf !== m_ovf) begin
        errors++;
        $display("FAIL random_cyc%0d got rdy=%0b head=%h cnt=%0d ovf=%0b want %0b %h %0d %0b",
                 n, bus.kb_ready, {bus.kb_flags, bus.kb_code}, bus.kb_count, bus.kb_ovf,
                 m_fifo.size() > 0, h, m_fifo.size(), m_ovf);
      end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_make_pop();
    test_prefixes();
    test_discard_pause();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
